// File: rtl/nios2_system_pio_led.sv
// Output-direction Avalon-MM PIO with a hardware one-shot inversion of selected bits.
// Optional PIO_LED_BITSET_EN maps OUTSET (addr 4) and OUTCLR (addr 5) set/clear writes.
module nios2_system_pio_led #(
  parameter int                    DATA_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    CNT_W       = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]      plen_q, plen_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           readdata_q, readdata_d;

  logic                  wr;
  logic                  pulse_wr;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [CNT_W-1:0]      wd_cnt;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign pulse_wr  = wr && (address == 3'd2);
  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign wd_cnt    = writedata[CNT_W-1:0];
  assign unused_wd = &{1'b0, writedata};

  always_comb begin
    data_d     = data_q;
    plen_d     = plen_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    readdata_d = '0;

    if (wr) begin
      case (address)
        3'd0: data_d = wd_data;
        3'd1: plen_d = (wd_cnt == '0) ? CNT_ONE : wd_cnt;
`ifdef PIO_LED_BITSET_EN
        3'd4: data_d = data_q | wd_data;
        3'd5: data_d = data_q & ~wd_data;
`endif
        default: ;
      endcase
    end

    // A PULSE write beats both the decrement and the expiry on the same edge.
    case (state_q)
      IDLE: begin
        if (pulse_wr && (wd_data != '0)) begin
          mask_d  = wd_data;
          cnt_d   = plen_q;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pulse_wr) begin
          mask_d = mask_q | wd_data;
          cnt_d  = plen_q;
        end else if (cnt_q == CNT_ONE) begin
          mask_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    case (address)
      3'd0:    readdata_d = 32'(data_q);
      3'd1:    readdata_d = 32'(plen_q);
      3'd2:    readdata_d = 32'(mask_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_q     <= RESET_VALUE;
      plen_q     <= CNT_ONE;
      mask_q     <= '0;
      cnt_q      <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      plen_q     <= plen_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q ^ mask_q;

endmodule

// File: tb/tb_nios2_system_pio_led.sv
// Scoreboard bench for nios2_system_pio_led: stimulus queues cycle-tagged expectations,
// a negedge monitor compares out_port/readdata when each tagged cycle comes due.
module tb_nios2_system_pio_led;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  nios2_system_pio_led #(
    .DATA_WIDTH (4),
    .RESET_VALUE(4'hA),
    .CNT_W      (24)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

`ifdef PIO_LED_BITSET_EN
  localparam bit BITSET = 1'b1;
`else
  localparam bit BITSET = 1'b0;
`endif

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        logic [31:0] act;
        act = sb_q[i].is_rd ? readdata : {28'd0, out_port};
        n_vec++;
        if (act !== sb_q[i].val) begin
          n_err++;
          $display("FAIL %s @cyc %0d: got 0x%08h, expected 0x%08h",
                   sb_q[i].is_rd ? "readdata" : "out_port", cyc, act, sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic push(input bit is_rd, input int at, input logic [31:0] val);
    exp_t e;
    e.cyc   = at;
    e.is_rd = is_rd;
    e.val   = val;
    sb_q.push_back(e);
  endtask

  task automatic idle_cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd7;
    writedata  = '0;
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [31:0] exp_val);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    writedata  = '0;
    push(1'b1, cyc + 1, exp_val);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] dexp;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd7;
    writedata  = '0;

    // reset for two clocks
    push(1'b0, 1, 32'hA);  push(1'b1, 1, 32'h0);
    push(1'b0, 2, 32'hA);  push(1'b1, 2, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    push(1'b0, cyc + 1, 32'hA);
    push(1'b1, cyc + 1, 32'h0);
    idle_cyc();
    bus_rd(3'd0, 32'hA);

    // DATA write and readback
    push(1'b0, cyc + 1, 32'h5);
    bus_wr(3'd0, 32'h5);
    bus_rd(3'd0, 32'h5);

    // PLEN=3 one-shot of 0b0011 on DATA=0
    push(1'b0, cyc + 1, 32'h0);
    bus_wr(3'd0, 32'h0);
    bus_wr(3'd1, 32'd3);
    for (int k = 1; k <= 4; k++) push(1'b0, cyc + k, (k <= 3) ? 32'h3 : 32'h0);
    bus_wr(3'd2, 32'h3);
    bus_rd(3'd2, 32'h3);
    bus_rd(3'd1, 32'h3);
    bus_rd(3'd2, 32'h3);
    bus_rd(3'd2, 32'h0);

    // retrigger: PLEN=5, PULSE=1 then PULSE=4 on pulse cycle 3
    bus_wr(3'd1, 32'd5);
    push(1'b0, cyc + 1, 32'h1);
    push(1'b0, cyc + 2, 32'h1);
    bus_wr(3'd2, 32'h1);
    idle_cyc();
    for (int k = 1; k <= 6; k++) push(1'b0, cyc + k, (k <= 5) ? 32'h5 : 32'h0);
    bus_wr(3'd2, 32'h4);
    repeat (5) idle_cyc();
    push(1'b0, cyc + 1, 32'h0);
    push(1'b0, cyc + 2, 32'h0);
    bus_wr(3'd2, 32'h0);
    bus_rd(3'd2, 32'h0);
    idle_cyc();

    // reset mid-pulse
    bus_wr(3'd1, 32'd10);
    push(1'b0, cyc + 1, 32'hF);
    push(1'b0, cyc + 2, 32'hF);
    push(1'b0, cyc + 3, 32'hF);
    bus_wr(3'd2, 32'hF);
    idle_cyc();
    idle_cyc();
    reset_n = 1'b0;
    push(1'b0, cyc + 1, 32'hA);
    push(1'b1, cyc + 1, 32'h0);
    idle_cyc();
    reset_n = 1'b1;
    push(1'b0, cyc + 1, 32'hA);
    bus_rd(3'd2, 32'h0);
    bus_rd(3'd1, 32'h1);
    bus_rd(3'd0, 32'hA);

    // OUTSET / OUTCLR (unmapped when the option is off)
    push(1'b0, cyc + 1, 32'h9);
    bus_wr(3'd0, 32'h9);
    push(1'b0, cyc + 1, BITSET ? 32'hB : 32'h9);
    bus_wr(3'd4, 32'h2);
    push(1'b0, cyc + 1, BITSET ? 32'h3 : 32'h9);
    bus_wr(3'd5, 32'h8);
    bus_rd(3'd4, 32'h0);
    bus_rd(3'd5, 32'h0);
    idle_cyc();

    // PLEN write of 0 stores 1; single-cycle pulse
    dexp = BITSET ? 4'h3 : 4'h9;
    bus_wr(3'd1, 32'h0);
    bus_rd(3'd1, 32'h1);
    push(1'b0, cyc + 1, {28'd0, dexp ^ 4'h2});
    push(1'b0, cyc + 2, {28'd0, dexp});
    bus_wr(3'd2, 32'h2);
    idle_cyc();

    // upper writedata bits ignored; write without chipselect ignored
    push(1'b0, cyc + 1, 32'h6);
    bus_wr(3'd0, 32'hFFFF_FFF6);
    bus_rd(3'd0, 32'h6);
    chipselect = 1'b0;
    write_n    = 1'b0;
    address    = 3'd0;
    writedata  = 32'h1;
    push(1'b0, cyc + 1, 32'h6);
    @(negedge clk);
    repeat (3) idle_cyc();

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
